// File: rtl/fp16_align_add.sv
// fp16_align_add: two-stage binary16 pre-normalizer (magnitude order, align, mantissa add/sub).
// Optional Inf/NaN detection is compiled in when FP16_ADD_SPECIAL_EN is defined.
module fp16_align_add (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic [4:0]  out_exp,
  output logic        out_sign,
  output logic        out_special,
  output logic [15:0] out_special_val
);

  logic        a_ge_b;
  logic [15:0] op_big;
  logic [15:0] op_sml;
  logic [4:0]  ee_big;
  logic [4:0]  ee_sml;
  logic [4:0]  shift_amt;
  logic [10:0] m_big;
  logic [10:0] m_sml;
  logic [10:0] m_sml_aligned;

  // NOTE: every always_comb output gets a value on every path (here unconditionally), so no latch is inferred.
  always_comb begin
    a_ge_b        = (in_a[14:0] >= in_b[14:0]);
    op_big        = a_ge_b ? in_a : in_b;
    op_sml        = a_ge_b ? in_b : in_a;
    ee_big        = (op_big[14:10] == 5'd0) ? 5'd1 : op_big[14:10];
    ee_sml        = (op_sml[14:10] == 5'd0) ? 5'd1 : op_sml[14:10];
    m_big         = {(op_big[14:10] != 5'd0), op_big[9:0]};
    m_sml         = {(op_sml[14:10] != 5'd0), op_sml[9:0]};
    shift_amt     = ee_big - ee_sml;
    // Shift counts of 11 or more leave nothing of the 11-bit mantissa.
    m_sml_aligned = m_sml >> shift_amt;
  end

  logic s1_valid_q;
  logic out_valid_q;
  logic s1_adv;
  logic s2_adv;
  logic s1_load;
  logic s2_load;

  assign s2_adv    = !out_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign s1_load   = in_valid && s1_adv;
  assign s2_load   = s1_valid_q && s2_adv;
  assign out_valid = out_valid_q;

  logic [10:0] s1_mbig_q;
  logic [10:0] s1_msml_q;
  logic [4:0]  s1_exp_q;
  logic        s1_sign_q;
  logic        s1_sub_q;

  logic [11:0] sum_d;
  logic        sign_d;
  logic [11:0] out_sum_q;
  logic [4:0]  out_exp_q;
  logic        out_sign_q;

  // Big has the larger magnitude, so the difference can never go negative.
  always_comb begin
    sum_d  = {1'b0, s1_mbig_q} + {1'b0, s1_msml_q};
    sign_d = s1_sign_q;
    if (s1_sub_q) begin
      sum_d = {1'b0, s1_mbig_q - s1_msml_q};
      if (sum_d == 12'd0) sign_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      // NOTE: data registers are reset too because their zero value is visible on the outputs.
      s1_mbig_q   <= '0;
      s1_msml_q   <= '0;
      s1_exp_q    <= '0;
      s1_sign_q   <= 1'b0;
      s1_sub_q    <= 1'b0;
      out_sum_q   <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q  <= in_valid;
      if (s2_adv) out_valid_q <= s1_valid_q;
      if (s1_load) begin
        s1_mbig_q <= m_big;
        s1_msml_q <= m_sml_aligned;
        s1_exp_q  <= ee_big;
        s1_sign_q <= op_big[15];
        s1_sub_q  <= in_a[15] ^ in_b[15];
      end
      if (s2_load) begin
        out_sum_q  <= sum_d;
        out_exp_q  <= s1_exp_q;
        out_sign_q <= sign_d;
      end
    end
  end

  assign out_sum  = out_sum_q;
  assign out_exp  = out_exp_q;
  assign out_sign = out_sign_q;

`ifdef FP16_ADD_SPECIAL_EN
  logic        nan_a;
  logic        nan_b;
  logic        inf_a;
  logic        inf_b;
  logic        special_d;
  logic [15:0] special_val_d;
  logic        s1_special_q;
  logic [15:0] s1_special_val_q;
  logic        out_special_q;
  logic [15:0] out_special_val_q;

  always_comb begin
    nan_a         = (&in_a[14:10]) && (|in_a[9:0]);
    nan_b         = (&in_b[14:10]) && (|in_b[9:0]);
    inf_a         = (&in_a[14:10]) && !(|in_a[9:0]);
    inf_b         = (&in_b[14:10]) && !(|in_b[9:0]);
    special_d     = (&in_a[14:10]) || (&in_b[14:10]);
    special_val_d = 16'h0000;
    if (nan_a || nan_b || (inf_a && inf_b && (in_a[15] != in_b[15])))
      special_val_d = 16'h7E00;
    else if (inf_a)
      special_val_d = {in_a[15], 5'h1F, 10'h000};
    else if (inf_b)
      special_val_d = {in_b[15], 5'h1F, 10'h000};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_special_q      <= 1'b0;
      s1_special_val_q  <= '0;
      out_special_q     <= 1'b0;
      out_special_val_q <= '0;
    end else begin
      if (s1_load) begin
        s1_special_q     <= special_d;
        s1_special_val_q <= special_val_d;
      end
      if (s2_load) begin
        out_special_q     <= s1_special_q;
        out_special_val_q <= s1_special_val_q;
      end
    end
  end

  assign out_special     = out_special_q;
  assign out_special_val = out_special_val_q;
`else
  assign out_special     = 1'b0;
  assign out_special_val = 16'h0000;
`endif

endmodule

// File: tb/tb_fp16_align_add.sv
// Self-checking bench for fp16_align_add: directed test-plan vectors, backpressure,
// reset behaviour and a randomized stream scored against an arithmetic reference model.
module tb_fp16_align_add;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_sum;
  logic [4:0]  out_exp;
  logic        out_sign;
  logic        out_special;
  logic [15:0] out_special_val;

  fp16_align_add dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sum        (out_sum),
    .out_exp        (out_exp),
    .out_sign       (out_sign),
    .out_special    (out_special),
    .out_special_val(out_special_val)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] sum;
    logic [4:0]  exp;
    logic        sign;
    logic        special;
    logic [15:0] sval;
  } res_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: value-level arithmetic on mantissas as plain integers.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t        r;
    logic [15:0] big;
    logic [15:0] sml;
    int          e_big, e_sml, m_big, m_sml, d, mag;
    bit          sub;
    if (int'(a[14:0]) >= int'(b[14:0])) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    e_big = (big[14:10] == 5'd0) ? 1 : int'(big[14:10]);
    e_sml = (sml[14:10] == 5'd0) ? 1 : int'(sml[14:10]);
    m_big = int'(big[9:0]) + ((big[14:10] != 5'd0) ? 1024 : 0);
    m_sml = int'(sml[9:0]) + ((sml[14:10] != 5'd0) ? 1024 : 0);
    d     = e_big - e_sml;
    m_sml = m_sml / (1 << d);
    sub   = a[15] ^ b[15];
    mag   = sub ? (m_big - m_sml) : (m_big + m_sml);
    r.sum     = mag[11:0];
    r.exp     = e_big[4:0];
    r.sign    = (sub && mag == 0) ? 1'b0 : big[15];
    r.special = 1'b0;
    r.sval    = 16'h0000;
`ifdef FP16_ADD_SPECIAL_EN
    begin
      bit a_max, b_max, a_nan, b_nan;
      a_max = (a[14:10] == 5'd31);
      b_max = (b[14:10] == 5'd31);
      a_nan = a_max && (a[9:0] != 0);
      b_nan = b_max && (b[9:0] != 0);
      if (a_max || b_max) begin
        r.special = 1'b1;
        if (a_nan || b_nan || (a_max && b_max && a[15] != b[15])) r.sval = 16'h7E00;
        else if (a_max) r.sval = {a[15], 15'h7C00};
        else            r.sval = {b[15], 15'h7C00};
      end
    end
`endif
    return r;
  endfunction

  function automatic res_t observe();
    return {out_sum, out_exp, out_sign, out_special, out_special_val};
  endfunction

  // One isolated transaction on an empty pipeline; reports result and latency.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, output res_t r, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 8);
    r = observe();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_checks++;
    if (out_valid !== 1'b0 || observe() !== res_t'(0)) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b res=%h want valid=0 res=0", out_valid, observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [8] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'hBC00, 16'h7BFF, 16'h0001, 16'h3C00, 16'hC000};
    logic [15:0] vb [8] = '{16'h3C00, 16'h3800, 16'hBC00, 16'h3C00, 16'h0001, 16'h0002, 16'hB800, 16'h3C00};
    logic [11:0] es [8] = '{12'h800, 12'h600, 12'h000, 12'h000, 12'h7FF, 12'h003, 12'h200, 12'h200};
    logic [4:0]  ee [8] = '{5'd15, 5'd15, 5'd15, 5'd15, 5'd30, 5'd1, 5'd15, 5'd16};
    logic        eg [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    res_t r, want;
    int   lat;
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], r, lat);
      want = {es[i], ee[i], eg[i], 1'b0, 16'h0000};
      n_checks++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL latency %h+%h: got %0d cycles want 2", va[i], vb[i], lat);
      end
      n_checks++;
      if (r !== want) begin
        n_fail++;
        $display("FAIL directed %h+%h: got %h want %h", va[i], vb[i], r, want);
      end
    end
  endtask

  task automatic test_special();
    logic [15:0] va [4] = '{16'h7C00, 16'hFC00, 16'h7E01, 16'h7C00};
    logic [15:0] vb [4] = '{16'hFC00, 16'h3C00, 16'h3C00, 16'h7C00};
`ifdef FP16_ADD_SPECIAL_EN
    logic        ef [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] ev [4] = '{16'h7E00, 16'hFC00, 16'h7E00, 16'h7C00};
`else
    logic        ef [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] ev [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
    res_t r;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], r, lat);
      n_checks++;
      if (lat !== 2 || r.special !== ef[i] || r.sval !== ev[i]) begin
        n_fail++;
        $display("FAIL special %h+%h: got lat=%0d flag=%b val=%h want lat=2 flag=%b val=%h",
                 va[i], vb[i], lat, r.special, r.sval, ef[i], ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [4] = '{16'h3C00, 16'h3C00, 16'h4000, 16'h0001};
    logic [15:0] pb [4] = '{16'h3C00, 16'h3800, 16'hBC00, 16'h0002};
    logic        rdy_want [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   sent = 0;
    int   got  = 0;
    res_t held = '0;
    res_t want;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      in_valid  = (sent < 4);
      if (sent < 4) begin in_a = pa[sent]; in_b = pb[sent]; end
      #1;
      if (cyc < 6) begin
        n_checks++;
        if (in_ready !== rdy_want[cyc]) begin
          n_fail++;
          $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, in_ready, rdy_want[cyc]);
        end
      end
      if (cyc == 2) held = observe();
      if (cyc == 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || observe() !== held) begin
          n_fail++;
          $display("FAIL bp_stall_stable: got valid=%b res=%h want valid=1 res=%h", out_valid, observe(), held);
        end
      end
      if (out_valid && out_ready) begin
        want = model(pa[got], pb[got]);
        n_checks++;
        if (observe() !== want) begin
          n_fail++;
          $display("FAIL bp_order #%0d: got %h want %h", got, observe(), want);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (got !== 4 || sent !== 4 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_count: got results=%0d sent=%0d valid=%b want 4/4/0", got, sent, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    bit spurious = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      in_a = 16'h3C00 + 16'(i); in_b = 16'h3800;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_prefill: got out_valid=%b want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== 12'h000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async: got valid=%b sum=%h in_ready=%b want 0/000/1", out_valid, out_sum, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) spurious = 1;
    end
    n_checks++;
    if (spurious) begin
      n_fail++;
      $display("FAIL midrst_no_emit: got out_valid pulse after release want none");
    end
  endtask

  task automatic test_random();
    res_t        exp_q [$];
    res_t        want;
    res_t        held = '0;
    bit          stalled = 0;
    int          sent = 0;
    logic [15:0] a, b;
    for (int cyc = 0; cyc < 3000 && (sent < 300 || exp_q.size() != 0); cyc++) begin
      @(negedge clk);
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || observe() !== held) begin
          n_fail++;
          $display("FAIL rand_stall_stable: got valid=%b res=%h want valid=1 res=%h", out_valid, observe(), held);
        end
      end
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        b = {1'($urandom_range(0, 1)), a[14:0] ^ 15'($urandom_range(0, 1023))};
      in_a = a; in_b = b;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: got unexpected result %h want none", observe());
        end else begin
          want = exp_q.pop_front();
          if (observe() !== want) begin
            n_fail++;
            $display("FAIL rand_result: got %h want %h", observe(), want);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = observe();
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || sent != 300) begin
      n_fail++;
      $display("FAIL rand_drain: got pending=%0d sent=%0d want 0/300", exp_q.size(), sent);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
